// File: rtl/dwt_pkg.sv
// Shared definitions for the integer Haar (S-transform) wavelet stages.
// Both the forward and the inverse stage import this package.
package dwt_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CLAMP_LO   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } state_t;

    // High coefficient carries one extra bit: difference of two unsigned samples.
    function automatic int coef_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int clamp_hi(input int dw);
        return (1 << dw) - 1;
    endfunction

endpackage

// File: rtl/haar_inv_core.sv
// Combinational inverse Haar lifting: b = L - floor(H/2), a = H + b,
// each result saturated to the unsigned sample range with a clip bit.
module haar_inv_core
    import dwt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] low,
    input  logic [DATA_W:0]   high,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              clip_a,
    output logic              clip_b
);

    localparam int AW = DATA_W + 3;
    localparam logic signed [AW-1:0] LO = AW'(CLAMP_LO);
    localparam logic signed [AW-1:0] HI = AW'(clamp_hi(DATA_W));

    logic signed [AW-1:0] l_ext;
    logic signed [AW-1:0] h_ext;
    logic signed [AW-1:0] a_raw;
    logic signed [AW-1:0] b_raw;

    assign l_ext = $signed({3'b000, low});
    assign h_ext = $signed({{2{high[DATA_W]}}, high});
    assign b_raw = l_ext - (h_ext >>> 1);
    assign a_raw = h_ext + b_raw;

    function automatic logic [DATA_W:0] sat(input logic signed [AW-1:0] v);
        if (v < LO)
            return {1'b1, {DATA_W{1'b0}}};
        else if (v > HI)
            return {1'b1, {DATA_W{1'b1}}};
        else
            return {1'b0, v[DATA_W-1:0]};
    endfunction

    assign {clip_a, a} = sat(a_raw);
    assign {clip_b, b} = sat(b_raw);

endmodule

// File: rtl/idwt_1d1l.sv
// One-level 1-D inverse Haar stage: accepts a (L, H) pair and emits the
// even then odd reconstructed sample over a valid/ready stream.
//
// state | meaning
// IDLE  | no pair held, ready for a new pair
// EVEN  | presenting even sample a
// ODD   | presenting odd sample b; may accept the next pair in the same cycle
module idwt_1d1l
    import dwt_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FRAME_PAIRS = 16,
    localparam int CNT_W      = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         low_i,
    input  logic [coef_w(DATA_W)-1:0] high_i,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         sample_o,
    output logic                      out_last,
    output logic [CNT_W-1:0]          pair_cnt_o,
    output logic                      frame_done,
    output logic                      clip_err
);

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              last_q;
    logic [DATA_W-1:0] core_a;
    logic [DATA_W-1:0] core_b;
    logic              core_clip_a;
    logic              core_clip_b;
    logic              accept;

    haar_inv_core #(.DATA_W(DATA_W)) u_core (
        .low    (low_i),
        .high   (high_i),
        .a      (core_a),
        .b      (core_b),
        .clip_a (core_clip_a),
        .clip_b (core_clip_b)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EVEN;
            EVEN:    if (out_ready) state_nxt = ODD;
            ODD:     if (out_ready) state_nxt = accept ? EVEN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sample_o  = '0;
        out_last  = 1'b0;
        case (state)
            IDLE: in_ready = !sys_rst;
            EVEN: begin
                out_valid = 1'b1;
                sample_o  = a_q;
            end
            ODD: begin
                out_valid = 1'b1;
                sample_o  = b_q;
                out_last  = last_q;
                in_ready  = out_ready && !sys_rst;
            end
            default: ;
        endcase
    end

    // Held pair, frame counter and status flags.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            a_q        <= '0;
            b_q        <= '0;
            last_q     <= 1'b0;
            pair_cnt_o <= '0;
            frame_done <= 1'b0;
            clip_err   <= 1'b0;
        end else begin
            frame_done <= (state == ODD) && out_ready && last_q;
            if (accept) begin
                a_q    <= core_a;
                b_q    <= core_b;
                last_q <= in_last;
                if (core_clip_a || core_clip_b)
                    clip_err <= 1'b1;
                if (in_last || (pair_cnt_o == CNT_W'(FRAME_PAIRS - 1)))
                    pair_cnt_o <= '0;
                else
                    pair_cnt_o <= pair_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: doc/idwt_1d1l.md
Name: idwt_1d1l

Overview:
Inverse of the one-dimensional, one-level integer Haar (S-transform) DWT stage. It consumes one low/high coefficient pair per handshake and reconstructs the two original samples, even sample first, then odd. It sits at the synthesis end of the wavelet chain, downstream of the coefficient storage or quantiser, and feeds the sample sink. It must reproduce forward-stage input bit-exactly; out-of-range coefficients are clamped and flagged.

Parameters:
DATA_W, 8, sample width and low-coefficient width (unsigned)
FRAME_PAIRS, 16, coefficient pairs per frame; sizes the pair counter (clog2(FRAME_PAIRS) bits)

Ports:
sys_clk  input  1  system clock, all logic rising-edge
sys_rst  input  1  synchronous, active-high reset
in_valid  input  1  coefficient pair valid
in_ready  output  1  block can accept a pair this cycle
low_i  input  DATA_W  low coefficient L, unsigned
high_i  input  DATA_W+1  high coefficient H, two's complement
in_last  input  1  pair is last of frame
out_valid  output  1  sample_o valid
out_ready  input  1  downstream accepts sample
sample_o  output  DATA_W  reconstructed sample, unsigned
out_last  output  1  high on the odd sample of the last pair
pair_cnt_o  output  clog2(FRAME_PAIRS)  pairs accepted in current frame
frame_done  output  1  one-cycle pulse when the odd sample of a last pair is accepted
clip_err  output  1  sticky flag; set when any sample is clamped

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst is synchronous and active-high.
- Reset values: out_valid=0, sample_o=0, out_last=0, pair_cnt_o=0, frame_done=0, clip_err=0, FSM=IDLE. in_ready=0 while sys_rst is high.
- Reset mid-operation discards the held pair and any partially emitted pair. No sample follows until a new pair is accepted.
- Arithmetic, signed, DATA_W+3 bits wide:
  - b = L - (H >>> 1), using an arithmetic shift, which is floor(H/2).
  - a = H + b.
  - Even sample = a, odd sample = b. This inverts forward H=a-b, L=b+floor(H/2).
- Clamp: a value below 0 becomes 0; a value above 2^DATA_W-1 becomes 2^DATA_W-1. clip_err sets on the cycle the clamped sample is registered. clip_err clears only on reset.
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. out_valid must not drop and sample_o/out_last must hold while out_ready is low.
- FSM:
  - IDLE: out_valid=0, in_ready=1. On an accepted pair, register the clamped a and b plus last, go to EVEN.
  - EVEN: sample_o=a, out_valid=1, in_ready=0. When out_ready is high, go to ODD.
  - ODD: sample_o=b, out_valid=1, out_last=held last, in_ready=out_ready.
    - out_ready high and in_valid high: accept the new pair in the same cycle, go to EVEN. This gives the back-to-back case.
    - out_ready high, no new pair: go to IDLE.
    - out_ready low: stay in ODD.
- Latency and throughput:
  - Pair accepted at edge N gives the even sample valid in cycle N+1 and the odd sample in cycle N+2 with no stall.
  - Sustained rate is one sample per cycle (one pair per two cycles).
- Pair counter:
  - Increments on each accepted pair.
  - Clears to 0 on accepting a pair with in_last=1, or after FRAME_PAIRS-1 wraps to 0.
  - in_last takes precedence: the counter reads 0 after a last pair.
- frame_done: pulses for one cycle on the edge where the odd sample with out_last=1 is accepted.
- Inputs are ignored while in_ready=0. in_valid may be high with no effect.

Decomposition:
- Shared package dwt_pkg holds:
  - DATA_W default
  - coefficient width function (DATA_W+1)
  - FSM state enum {IDLE, EVEN, ODD}
  - clamp bounds
- The forward stage imports the same package.
- Sub-module haar_inv_core: purely combinational lifting plus clamp. Inputs L and H; outputs a, b and the two clip bits. The top holds the FSM, registers, counter and handshake.

Test Plan:
- Basic pair: L=80, H=40, out_ready=1 -> samples 100 then 60 on consecutive cycles, clip_err=0.
- Negative H: L=11, H=-3 -> samples 10 then 13, with floor rounding checked.
- Back-to-back with last: stream (80,40),(11,-3),(0,0) with in_last on the third, in_valid held high.
  - Samples are 100,60,10,13,0,0 with no bubble.
  - out_last and frame_done fire on the final 0.
  - pair_cnt_o returns to 0.
- Backpressure: hold out_ready=0 for 3 cycles in EVEN and again in ODD -> sample_o stays stable, in_ready=0, no pair is lost or duplicated.
- Clamp: (L=255, H=200) gives 255 then 155 with clip_err=1. Then (L=0, H=100) gives 50 then 0. clip_err stays 1.
- Reset mid-pair: assert sys_rst while in ODD -> next cycle out_valid=0, pair_cnt_o=0, clip_err=0, and no stale sample appears after reset deasserts.
